// File: rtl/sensor_pkg.sv
// Definitions shared by the command-table decoder, the response sender and their benches.
package sensor_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSendHi,
        StGap,
        StSendLo,
        StDone
    } send_state_e;

    localparam logic [7:0] RspCode1F = 8'h1F;
    localparam logic [7:0] RspCode08 = 8'h08;
    localparam logic [7:0] RspCode09 = 8'h09;
    localparam logic [7:0] RspCode0A = 8'h0A;
    localparam logic [7:0] RspCode0B = 8'h0B;
    localparam logic [7:0] RspCode0C = 8'h0C;
    localparam logic [7:0] RspVoid   = 8'hFF;
    localparam logic [7:0] RspCodeCF = 8'hCF;
    localparam logic [7:0] RspCodeEF = 8'hEF;
    localparam logic [7:0] RspCodeDF = 8'hDF;
    localparam logic [7:0] RspCode6F = 8'h6F;

    localparam logic [7:0] CmdCode01 = 8'h01;
    localparam logic [7:0] CmdCode02 = 8'h02;
    localparam logic [7:0] CmdCode03 = 8'h03;
    localparam logic [7:0] CmdCode04 = 8'h04;
    localparam logic [7:0] CmdCode05 = 8'h05;
    localparam logic [7:0] CmdCode06 = 8'h06;
    localparam logic [7:0] CmdCode07 = 8'h07;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; 'last' flags the final counted cycle (count == 1).
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/response_sender.sv
// Serialises a 16-bit response word as two bytes (high first) over a valid/ready link,
// with a programmable inter-byte gap and a stall watchdog.
module response_sender
    import sensor_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send_req,
    input  logic [15:0] buffer_tx,
    input  logic        tx_ready,
    input  logic        clear_err,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        send_done,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int unsigned GapWidth = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned WdWidth  = $clog2(TIMEOUT_CYCLES + 1);

    send_state_e state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        timeout_q, overrun_q;
    logic        gap_load, gap_last;
    logic        wd_load, wd_dec, wd_last;
    logic        timeout_evt;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        send_done   = 1'b0;
        gap_load    = 1'b0;
        wd_dec      = 1'b0;
        timeout_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (send_req) begin
                    if (buffer_tx != 16'h0000) begin
                        hold_d  = buffer_tx;
                        state_d = StSendHi;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSendHi: begin
                tx_valid = 1'b1;
                tx_data  = hold_q[15:8];
                if (tx_ready) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = StSendLo;
                    end else begin
                        gap_load = 1'b1;
                        state_d  = StGap;
                    end
                end else if (wd_last) begin
                    // tx_valid falls with the move to DONE on the next clock
                    timeout_evt = 1'b1;
                    state_d     = StDone;
                end else begin
                    wd_dec = 1'b1;
                end
            end
            StGap: begin
                if (gap_last) begin
                    state_d = StSendLo;
                end
            end
            StSendLo: begin
                tx_valid = 1'b1;
                tx_data  = hold_q[7:0];
                if (tx_ready) begin
                    state_d = StDone;
                end else if (wd_last) begin
                    timeout_evt = 1'b1;
                    state_d     = StDone;
                end else begin
                    wd_dec = 1'b1;
                end
            end
            StDone: begin
                send_done = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign wd_load = (state_d != state_q) && ((state_d == StSendHi) || (state_d == StSendLo));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            hold_q    <= 16'h0000;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            // A set event in the same cycle as clear_err keeps the flag high
            timeout_q <= timeout_evt | (timeout_q & ~clear_err);
            overrun_q <= (send_req & busy) | (overrun_q & ~clear_err);
        end
    end

    assign timeout_err = timeout_q;
    assign overrun_err = overrun_q;

    cycle_timer #(
        .WIDTH (GapWidth)
    ) u_gap_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GapWidth'(GAP_CYCLES)),
        .dec        (state_q == StGap),
        .last       (gap_last)
    );

    cycle_timer #(
        .WIDTH (WdWidth)
    ) u_wd_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (wd_load),
        .load_value (WdWidth'(TIMEOUT_CYCLES)),
        .dec        (wd_dec),
        .last       (wd_last)
    );

endmodule

// File: tb/tb_response_sender.sv
// Scoreboard bench for response_sender: directed scenarios followed by random words.
module tb_response_sender;
    import sensor_pkg::*;

    localparam int unsigned Gap = 4;
    localparam int unsigned Tmo = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        send_req = 1'b0;
    logic [15:0] buffer_tx = 16'h0000;
    logic        tx_ready = 1'b0;
    logic        clear_err = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        send_done;
    logic        timeout_err;
    logic        overrun_err;

    response_sender #(
        .GAP_CYCLES     (Gap),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .send_req    (send_req),
        .buffer_tx   (buffer_tx),
        .tx_ready    (tx_ready),
        .clear_err   (clear_err),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .busy        (busy),
        .send_done   (send_done),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] sb_q[$];
    int done_count = 0;
    int valid_count = 0;
    int hs_count = 0;
    int last_hs_cyc = 0;
    int prev_hs_cyc = 0;
    int last_done_cyc = 0;
    int req_cyc = 0;
    bit allow_drop = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, pops the scoreboard on every handshake
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_valid = 1'b0;
            end else begin
                if (tx_valid) valid_count++;
                if (prev_valid && !prev_ready) begin
                    if (tx_valid) check("data_stable", tx_data, prev_data);
                    else if (!allow_drop) check("valid_dropped", 0, 1);
                end
                if (tx_valid && tx_ready) begin
                    hs_count++;
                    prev_hs_cyc = last_hs_cyc;
                    last_hs_cyc = cyc;
                    if (sb_q.size() == 0) check("unexpected_byte", tx_data, -1);
                    else check("byte", tx_data, sb_q.pop_front());
                end
                if (send_done) begin
                    done_count++;
                    last_done_cyc = cyc;
                end
                prev_valid = tx_valid;
                prev_ready = tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input bit push);
        buffer_tx = w;
        send_req  = 1'b1;
        req_cyc   = cyc + 1;
        if (push && (w != 16'h0000)) begin
            sb_q.push_back(w[15:8]);
            sb_q.push_back(w[7:0]);
        end
        tick(1);
        send_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int d0;
        int v0;
        int h0;
        int n;
        int stall;
        logic [15:0] w;

        #12;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_send_done", send_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_overrun_err", overrun_err, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        tick(2);

        // Normal transfer with ready always high: bytes Gap+1 clocks apart
        tx_ready = 1'b1;
        d0 = done_count;
        send({RspCode0A, 8'h19}, 1'b1);
        wait_idle("s1_idle");
        check("s1_spacing", last_hs_cyc - prev_hs_cyc, Gap + 1);
        check("s1_done", done_count - d0, 1);
        check("s1_sb_empty", sb_q.size(), 0);

        // All-zero word: discarded, send_done one clock after acceptance
        d0 = done_count;
        v0 = valid_count;
        send(16'h0000, 1'b0);
        wait_idle("s2_idle");
        check("s2_no_valid", valid_count - v0, 0);
        check("s2_done", done_count - d0, 1);
        check("s2_done_cycle", last_done_cyc, req_cyc);

        // Transmitter stalled: high byte offered for Tmo clocks, then aborted
        tx_ready   = 1'b0;
        allow_drop = 1'b1;
        d0 = done_count;
        v0 = valid_count;
        h0 = hs_count;
        send({RspCode1F, RspVoid}, 1'b0);
        wait_idle("s3_idle");
        check("s3_valid_cycles", valid_count - v0, Tmo);
        check("s3_no_handshake", hs_count - h0, 0);
        check("s3_timeout_err", timeout_err, 1);
        check("s3_done", done_count - d0, 1);
        allow_drop = 1'b0;
        clear_err  = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("s3_cleared", timeout_err, 0);

        // Input word changes while the high byte waits for ready
        tx_ready = 1'b0;
        d0 = done_count;
        send({RspCode09, 8'h55}, 1'b1);
        tick(1);
        buffer_tx = 16'h3C3C;
        check("s4_valid", tx_valid, 1);
        check("s4_data_held", tx_data, RspCode09);
        n = 0;
        while (busy && n < 200) begin
            tx_ready = ~tx_ready;
            tick(1);
            n++;
        end
        check("s4_idle", busy, 0);
        check("s4_done", done_count - d0, 1);
        check("s4_sb_empty", sb_q.size(), 0);
        check("s4_no_err", timeout_err, 0);

        // Request during the gap is ignored; set beats a simultaneous clear
        tx_ready = 1'b1;
        d0 = done_count;
        send({RspCode0B, RspVoid}, 1'b1);
        tick(1);
        buffer_tx = {RspCode0C, RspVoid};
        send_req  = 1'b1;
        clear_err = 1'b1;
        tick(1);
        send_req  = 1'b0;
        clear_err = 1'b0;
        check("s5_overrun", overrun_err, 1);
        wait_idle("s5_idle");
        check("s5_done", done_count - d0, 1);
        check("s5_sb_empty", sb_q.size(), 0);
        check("s5_overrun_sticky", overrun_err, 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("s5_cleared", overrun_err, 0);

        // Reset while the low byte is pending
        tx_ready = 1'b1;
        send({RspCode0A, 8'h5A}, 1'b1);
        tick(1);
        tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 20) begin
            tick(1);
            n++;
        end
        check("s6_lo_offered", tx_data, 8'h5A);
        #2 reset = 1'b0;
        #1;
        check("s6_rst_valid", tx_valid, 0);
        check("s6_rst_data", tx_data, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_done", send_done, 0);
        sb_q.delete();
        d0 = done_count;
        tick(3);
        reset = 1'b1;
        tick(2);
        check("s6_no_done", done_count - d0, 0);
        tx_ready = 1'b1;
        send({RspCode0C, 8'h42}, 1'b1);
        wait_idle("s6_idle");
        check("s6_resume_done", done_count - d0, 1);
        check("s6_sb_empty", sb_q.size(), 0);

        // Random words with random backpressure, never stalling long enough to time out
        for (int i = 0; i < 30; i++) begin
            w = 16'($urandom);
            if (i == 0) w = 16'h0001;
            else if ($urandom_range(0, 5) == 0) w = 16'h0000;
            d0 = done_count;
            tx_ready = 1'($urandom_range(0, 1));
            send(w, 1'b1);
            stall = 0;
            n = 0;
            while (busy && n < 200) begin
                if (tx_valid) begin
                    tx_ready = (stall >= 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    stall = tx_ready ? 0 : stall + 1;
                end else begin
                    tx_ready = 1'($urandom_range(0, 1));
                    stall = 0;
                end
                tick(1);
                n++;
            end
            check("rnd_idle", busy, 0);
            check("rnd_done", done_count - d0, 1);
            check("rnd_sb_empty", sb_q.size(), 0);
        end
        check("end_timeout_err", timeout_err, 0);
        check("end_overrun_err", overrun_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
